// File: rtl/mp_addsub_ctrl_if.sv
// mp_addsub_ctrl_if: request/result handshake bundle for the multi-precision add/sub sequencer
interface mp_addsub_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         add_sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;
    logic         busy;
    modport slave (
        input  req_valid, a, b, add_sub, res_ready,
        output req_ready, res_valid, result, carry, ovf, busy
    );
    modport master (
        output req_valid, a, b, add_sub, res_ready,
        input  req_ready, res_valid, result, carry, ovf, busy
    );
endinterface

// File: rtl/mp_addsub_ctrl.sv
// mp_addsub_ctrl: byte-serial NBYTES-wide add/subtract over one 8-bit ripple slice
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module mp_addsub_ctrl #(
    parameter int NBYTES = 4
) (
    input logic             clk,
    input logic             rst_n,
    mp_addsub_ctrl_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]  a_r, b_r, result_r;
    logic          op_r, cy_r, carry_r, ovf_r;
    logic [CW-1:0] cnt;
    logic [CW+2:0] base;
    logic [7:0]    a_byte, b_x, sum;
    logic [8:0]    c;

    // Subtract is A + ~B + 1: the +1 enters as the initial carry latched at accept.
    assign base   = {cnt, 3'b000};
    assign a_byte = a_r[base +: 8];
    assign b_x    = b_r[base +: 8] ^ {8{op_r}};
    assign c[0]   = cy_r;

    for (genvar i = 0; i < 8; i++) begin : g_slice
        full_adder u_fa (.a(a_byte[i]), .b(b_x[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.req_valid)  state_nx = RUN;
        if (state == RUN && cnt == LAST)     state_nx = DONE;
        if (state == DONE && bus.res_ready)  state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= 1'b0;
            cy_r     <= 1'b0;
            cnt      <= '0;
            result_r <= '0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (state == IDLE && bus.req_valid) begin
            a_r  <= bus.a;
            b_r  <= bus.b;
            op_r <= bus.add_sub;
            cy_r <= bus.add_sub;
            cnt  <= '0;
        end else if (state == RUN) begin
            result_r[base +: 8] <= sum;
            cy_r                <= c[8];
            if (cnt != LAST) cnt <= cnt + 1'b1;
            else begin
                carry_r <= c[8];
                ovf_r   <= c[8] ^ c[7];
            end
        end

    assign bus.req_ready = state == IDLE;
    assign bus.busy      = state == RUN;
    assign bus.res_valid = state == DONE;
    assign bus.result    = result_r;
    assign bus.carry     = carry_r;
    assign bus.ovf       = ovf_r;
endmodule
